// File: rtl/float_div_mul_result_stage.sv
// Result stage behind a LAT-cycle multiplier: tracks in-flight tokens, buffers results in a
// DEPTH-entry FIFO and back-pressures the multiplier. Optional class flags: FLOAT_DIV_MUL_RES_FLAGS_EN.
module float_div_mul_result_stage #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        in_valid,
    input  logic [31:0] mul_x,
    input  logic        out_ready,
    output logic        astall,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [LAT-1:0] valid_sr;
    logic [LAT-1:0] valid_sr_next;
    logic           last_valid;
    logic           full;
    logic           push;
    logic           pop;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [31:0]    data_mem [DEPTH];

    // Handshake: a token issues on in_valid & ~astall; a result leaves on out_valid & out_ready.
    // Neither side may assume its request was taken unless both signals were high together.
    if (LAT == 1) begin : g_sr_single
        assign valid_sr_next = in_valid;
    end else begin : g_sr_multi
        assign valid_sr_next = {valid_sr[LAT-2:0], in_valid};
    end

    assign last_valid = valid_sr[LAT-1];
    assign full       = (count == FULL_COUNT);
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign astall     = full & last_valid & ~pop;
    assign push       = last_valid & ~astall;

    // The token pipeline freezes together with the multiplier so latency counts enabled cycles only.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            valid_sr <= '0;
        end else if (!astall) begin
            valid_sr <= valid_sr_next;
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds no reset; the output mux hides stale entries while empty.
    always_ff @(posedge aclk) begin
        if (push) begin
            data_mem[wr_ptr] <= mul_x;
        end
    end

    assign out_data = out_valid ? data_mem[rd_ptr] : 32'h0000_0000;

`ifdef FLOAT_DIV_MUL_RES_FLAGS_EN
    logic [3:0] flag_mem [DEPTH];
    logic [7:0] x_exp;
    logic       man_zero;
    logic [3:0] push_flags;

    assign x_exp      = mul_x[30:23];
    assign man_zero   = (mul_x[22:0] == 23'd0);
    // Class order {nan, inf, zero, subnormal}; normal numbers carry no flag.
    assign push_flags = {(x_exp == 8'hFF) & ~man_zero,
                         (x_exp == 8'hFF) &  man_zero,
                         (x_exp == 8'h00) &  man_zero,
                         (x_exp == 8'h00) & ~man_zero};

    always_ff @(posedge aclk) begin
        if (push) begin
            flag_mem[wr_ptr] <= push_flags;
        end
    end

    assign out_flags = out_valid ? flag_mem[rd_ptr] : 4'b0000;
`else
    assign out_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_float_div_mul_result_stage.sv
// Bench for float_div_mul_result_stage: a multiplier model feeding the DUT, a result
// scoreboard queue, table-driven class vectors, directed corner sequences and random traffic.
module tb_float_div_mul_result_stage;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
`ifdef FLOAT_DIV_MUL_RES_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic        aclk      = 1'b0;
    logic        arst_n    = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] mul_x     = 32'h0;
    logic        out_ready = 1'b0;
    logic        astall;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_flags;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_issued   = 0;
    int n_dut_pops = 0;

    // Scoreboard: results the FIFO should hold, head first.
    logic [31:0] exp_q[$];
    // Multiplier model: LAT stages, enabled by ~stall.
    logic        pipe_v [LAT];
    logic [31:0] pipe_d [LAT];

    typedef struct {
        logic [31:0] x;
        logic [3:0]  flags_on;
    } vec_t;
    vec_t vecs [6];

    // Clock / reset
    always #5 aclk = ~aclk;

    float_div_mul_result_stage #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .mul_x     (mul_x),
        .out_ready (out_ready),
        .astall    (astall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    function automatic logic [3:0] exp_class(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] m;
        e = x[30:23];
        m = x[22:0];
        if (!FLAGS_EN) return 4'b0000;
        if (e == 8'hFF) return (m != 23'd0) ? 4'b1000 : 4'b0100;
        if (e == 8'h00) return (m == 23'd0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 32'h0;
        end
    endtask

    // Driver: one clock cycle, entered and left just after a falling edge.
    task automatic step(input logic iv, input logic ordy, input logic [31:0] val);
        logic exp_pop;
        logic exp_stall;
        in_valid  = iv;
        out_ready = ordy;
        mul_x     = pipe_v[LAT-1] ? pipe_d[LAT-1] : $urandom();
        #1;
        exp_pop   = (exp_q.size() != 0) && ordy;
        exp_stall = (exp_q.size() == DEPTH) && pipe_v[LAT-1] && !exp_pop;
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        chk("out_flags", {28'b0, out_flags},
            {28'b0, (exp_q.size() != 0) ? exp_class(exp_q[0]) : 4'b0000});
        chk("astall", {31'b0, astall}, {31'b0, exp_stall});
        if (out_valid && ordy) n_dut_pops++;
        @(posedge aclk);
        if (exp_pop) void'(exp_q.pop_front());
        if (!exp_stall) begin
            if (pipe_v[LAT-1]) exp_q.push_back(pipe_d[LAT-1]);
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = iv;
            pipe_d[0] = val;
            if (iv) n_issued++;
        end
        @(negedge aclk);
    endtask

    task automatic reset_pulse(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        arst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_flags"}, {28'b0, out_flags}, 32'h0);
        chk({tag, "_astall"}, {31'b0, astall}, 32'h0);
        model_clear();
        n_issued = n_dut_pops;
        @(negedge aclk);
        arst_n = 1'b1;
    endtask

    initial begin
        int base;
        model_clear();
        vecs[0] = '{32'h7FC0_0000, 4'b1000};
        vecs[1] = '{32'hFF80_0000, 4'b0100};
        vecs[2] = '{32'h8000_0000, 4'b0010};
        vecs[3] = '{32'h0000_0001, 4'b0001};
        vecs[4] = '{32'h4040_0000, 4'b0000};
        vecs[5] = '{32'h7F80_0001, 4'b1000};

        // Reset state
        @(negedge aclk);
        reset_pulse("reset");

        // Single issue: result visible three cycles after issue
        step(1'b1, 1'b1, 32'h4040_0000);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        #1;
        chk("lat_valid", {31'b0, out_valid}, 32'h1);
        chk("lat_data", out_data, 32'h4040_0000);
        chk("lat_flags", {28'b0, out_flags}, 32'h0);
        step(1'b0, 1'b1, 32'h0);

        // Classification table
        for (int v = 0; v < 6; v++) begin
            step(1'b1, 1'b1, vecs[v].x);
            step(1'b0, 1'b1, 32'h0);
            step(1'b0, 1'b1, 32'h0);
            #1;
            chk("vec_valid", {31'b0, out_valid}, 32'h1);
            chk("vec_data", out_data, vecs[v].x);
            chk("vec_flags", {28'b0, out_flags}, {28'b0, FLAGS_EN ? vecs[v].flags_on : 4'b0000});
            step(1'b0, 1'b1, 32'h0);
        end

        // Back-to-back issue with a ready consumer
        base = n_dut_pops;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h3F80_0000 + i);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h0);
        chk("b2b_count", n_dut_pops - base, 32'd8);

        // Fill with consumer blocked, then release
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $urandom());
        #1;
        chk("full_valid", {31'b0, out_valid}, 32'h1);
        chk("full_astall", {31'b0, astall}, 32'h1);
        step(1'b1, 1'b1, $urandom());
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 32'h0);
        chk("full_nolost", n_dut_pops, n_issued);

        // Reset with 3 buffered and 2 in flight
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom());
        reset_pulse("midrst");
        base = n_dut_pops;
        step(1'b1, 1'b1, 32'h4120_0000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0);
        chk("midrst_one", n_dut_pops - base, 32'd1);

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            logic iv;
            logic ordy;
            if (((i / 1000) % 2) == 0) begin
                iv   = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 3) == 0);
            end else begin
                iv   = ($urandom_range(0, 1) != 0);
                ordy = ($urandom_range(0, 3) != 0);
            end
            step(iv, ordy, $urandom());
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'h0);
        chk("rand_count", n_dut_pops, n_issued);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
